// File: rtl/jtcop_mcu_mailbox.sv
// MCU-side mailbox between the 68000 and the MCU: 16-bit words in, 16-bit replies out with a sec2 pulse.
// Optional build macro JTCOP_MBOX_IRQ_EN drives mcu_irqn from rx_full; otherwise mcu_irqn is tied high.
module jtcop_mcu_mailbox #(
  parameter int SEC2_LEN = 8,
  parameter int GAP_LEN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] main_din,
  input  logic        main_wr,
  input  logic        main_rd,
  output logic [15:0] main_dout,
  output logic        sec2,
  input  logic        mcu_cs,
  input  logic        mcu_wr,
  input  logic        mcu_rd,
  input  logic [1:0]  mcu_addr,
  input  logic [7:0]  mcu_din,
  output logic [7:0]  mcu_dout,
  output logic        mcu_irqn
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [7:0] PULSE_INIT = 8'(SEC2_LEN - 1);
  localparam logic [7:0] GAP_INIT   = 8'(GAP_LEN - 1);

  logic        main_wr_q, main_wr_d;
  logic        main_rd_q, main_rd_d;
  logic [15:0] rx_q, rx_d;
  logic        rx_full_q, rx_full_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  stage_lo_q, stage_lo_d;
  logic        tx_pend_q, tx_pend_d;
  logic [15:0] main_dout_q, main_dout_d;
  logic        sec2_q, sec2_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] queue_q, queue_d;
  logic        qvalid_q, qvalid_d;

  logic        rx_capture, rd_hi, rd_status, wr_lo, commit, rd_fall, can_load;
  logic [15:0] commit_word;

  // MCU side: mcu_wr/mcu_rd are one-clk strobes, valid only with mcu_cs; no ready, every strobe
  // is acted on in the clk it is seen. Main side: main_wr/main_rd are levels, acted on at edges.
  always_comb begin
    rx_capture  = main_wr & ~main_wr_q;
    rd_fall     = ~main_rd & main_rd_q;
    rd_hi       = mcu_cs & mcu_rd & (mcu_addr == 2'd1);
    rd_status   = mcu_cs & mcu_rd & (mcu_addr == 2'd2);
    wr_lo       = mcu_cs & mcu_wr & (mcu_addr == 2'd0);
    commit      = mcu_cs & mcu_wr & (mcu_addr == 2'd1);
    commit_word = {mcu_din, stage_lo_q};
    can_load    = ~main_rd;
  end

  always_comb begin
    main_wr_d  = main_wr;
    main_rd_d  = main_rd;
    rx_d       = rx_capture ? main_din : rx_q;
    rx_full_d  = rx_capture ? 1'b1 : (rd_hi ? 1'b0 : rx_full_q);
    overrun_d  = (rx_capture & rx_full_q) ? 1'b1 : (rd_status ? 1'b0 : overrun_q);
    stage_lo_d = wr_lo ? mcu_din : stage_lo_q;
    tx_pend_d  = commit ? 1'b1 : (rd_fall ? 1'b0 : tx_pend_q);
  end

  // Reply FSM: loads into main_dout only while the 68000 is not reading it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sec2_d      = sec2_q;
    main_dout_d = main_dout_q;
    queue_d     = queue_q;
    qvalid_d    = qvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (commit && can_load) begin
          main_dout_d = commit_word;
          qvalid_d    = 1'b0;
          sec2_d      = 1'b1;
          cnt_d       = PULSE_INIT;
          state_d     = ST_PULSE;
        end else if (commit) begin
          queue_d  = commit_word;
          qvalid_d = 1'b1;
        end else if (qvalid_q && can_load) begin
          main_dout_d = queue_q;
          qvalid_d    = 1'b0;
          sec2_d      = 1'b1;
          cnt_d       = PULSE_INIT;
          state_d     = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (commit) begin
          queue_d  = commit_word;
          qvalid_d = 1'b1;
        end
        if (cnt_q == 8'd0) begin
          sec2_d  = 1'b0;
          cnt_d   = GAP_INIT;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (commit) begin
          queue_d  = commit_word;
          qvalid_d = 1'b1;
        end
        if (cnt_q == 8'd0) begin
          if (qvalid_q && can_load) begin
            // a commit landing on this same clk stays queued behind the word being loaded
            main_dout_d = queue_q;
            qvalid_d    = commit;
            sec2_d      = 1'b1;
            cnt_d       = PULSE_INIT;
            state_d     = ST_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sec2_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_wr_q   <= 1'b0;
      main_rd_q   <= 1'b0;
      rx_q        <= 16'h0000;
      rx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      stage_lo_q  <= 8'h00;
      tx_pend_q   <= 1'b0;
      main_dout_q <= 16'h0000;
      sec2_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 8'h00;
      queue_q     <= 16'h0000;
      qvalid_q    <= 1'b0;
    end else begin
      main_wr_q   <= main_wr_d;
      main_rd_q   <= main_rd_d;
      rx_q        <= rx_d;
      rx_full_q   <= rx_full_d;
      overrun_q   <= overrun_d;
      stage_lo_q  <= stage_lo_d;
      tx_pend_q   <= tx_pend_d;
      main_dout_q <= main_dout_d;
      sec2_q      <= sec2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      queue_q     <= queue_d;
      qvalid_q    <= qvalid_d;
    end
  end

  always_comb begin
    case (mcu_addr)
      2'd0:    mcu_dout = rx_q[7:0];
      2'd1:    mcu_dout = rx_q[15:8];
      2'd2:    mcu_dout = {5'b00000, overrun_q, tx_pend_q, rx_full_q};
      default: mcu_dout = 8'hff;
    endcase
  end

  assign main_dout = main_dout_q;
  assign sec2      = sec2_q;

`ifdef JTCOP_MBOX_IRQ_EN
  assign mcu_irqn = ~rx_full_q;
`else
  assign mcu_irqn = 1'b1;
`endif

endmodule

// File: tb/tb_jtcop_mcu_mailbox.sv
// Bench for jtcop_mcu_mailbox: RX path from a vector table, TX path scoreboarded on sec2 rising edges.
module tb_jtcop_mcu_mailbox;

  localparam int SEC2_LEN = 8;
  localparam int GAP_LEN  = 2;
`ifdef JTCOP_MBOX_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_IRQ = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [1:0]  addr;
    logic [7:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] main_din;
  logic        main_wr, main_rd;
  logic [15:0] main_dout;
  logic        sec2;
  logic        mcu_cs, mcu_wr, mcu_rd;
  logic [1:0]  mcu_addr;
  logic [7:0]  mcu_din, mcu_dout;
  logic        mcu_irqn;

  int n_vec = 0;
  int n_miss = 0;
  int pulses_seen = 0;
  logic [15:0] exp_q[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  jtcop_mcu_mailbox #(.SEC2_LEN(SEC2_LEN), .GAP_LEN(GAP_LEN)) dut (
    .clk(clk), .rst(rst),
    .main_din(main_din), .main_wr(main_wr), .main_rd(main_rd), .main_dout(main_dout),
    .sec2(sec2),
    .mcu_cs(mcu_cs), .mcu_wr(mcu_wr), .mcu_rd(mcu_rd), .mcu_addr(mcu_addr),
    .mcu_din(mcu_din), .mcu_dout(mcu_dout), .mcu_irqn(mcu_irqn)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic main_write(input logic [15:0] d);
    main_din = d;
    main_wr  = 1'b1;
    repeat (6) tick();
    main_wr = 1'b0;
    tick();
  endtask

  task automatic mcu_read(input logic [1:0] a, output logic [7:0] d);
    mcu_cs = 1'b1; mcu_rd = 1'b1; mcu_addr = a;
    @(negedge clk);
    d = mcu_dout;
    @(posedge clk);
    #1;
    mcu_cs = 1'b0; mcu_rd = 1'b0;
  endtask

  task automatic mcu_write(input logic [1:0] a, input logic [7:0] d);
    mcu_cs = 1'b1; mcu_wr = 1'b1; mcu_addr = a; mcu_din = d;
    @(posedge clk);
    #1;
    mcu_cs = 1'b0; mcu_wr = 1'b0;
  endtask

  task automatic wait_sec2(input logic lvl, input int limit);
    int n = 0;
    while (sec2 !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sec2 !== lvl) begin
      n_vec++;
      n_miss++;
      $display("FAIL sec2_wait: sec2 is %b, needed %b within %0d clks", sec2, lvl, limit);
    end
  endtask

  // sec2 monitor: pulse width, gap width and the reply word at each rising edge
  logic sec2_prev = 1'b0;
  int   hi_cnt = 0;
  int   lo_cnt = 0;
  bit   seen_fall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sec2_prev = 1'b0; hi_cnt = 0; lo_cnt = 0; seen_fall = 1'b0;
    end else begin
      if (sec2 && !sec2_prev) begin
        pulses_seen++;
        if (seen_fall) check("gap_len_min", 16'(lo_cnt >= GAP_LEN), 16'd1);
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL reply_word: got %h with no reply expected", main_dout);
        end else begin
          check("reply_word", main_dout, exp_q.pop_front());
        end
        hi_cnt = 1;
      end else if (sec2) begin
        hi_cnt++;
      end else if (sec2_prev) begin
        check("sec2_len", 16'(hi_cnt), 16'(SEC2_LEN));
        lo_cnt = 1;
        seen_fall = 1'b1;
      end else begin
        lo_cnt++;
      end
      sec2_prev = sec2;
    end
  end

  initial begin
    logic [7:0] rd;
    logic [15:0] r;

    rst = 1'b1;
    main_din = 16'h0; main_wr = 1'b0; main_rd = 1'b0;
    mcu_cs = 1'b0; mcu_wr = 1'b0; mcu_rd = 1'b0; mcu_addr = 2'd2; mcu_din = 8'h0;

    // RX vectors: 68000 writes, then MCU reads / irq checks
    vt.push_back(vec_t'{OP_WR,  16'h1234, 2'd0, 8'h00});
    vt.push_back(vec_t'{OP_IRQ, 16'h0000, 2'd0, 8'h01});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd2, 8'h01});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd0, 8'h34});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd1, 8'h12});
    vt.push_back(vec_t'{OP_IRQ, 16'h0000, 2'd0, 8'h00});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd2, 8'h00});
    vt.push_back(vec_t'{OP_WR,  16'hAAAA, 2'd0, 8'h00});
    vt.push_back(vec_t'{OP_WR,  16'h5555, 2'd0, 8'h00});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd2, 8'h05});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd0, 8'h55});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd1, 8'h55});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd2, 8'h00});
    vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd3, 8'hff});
    for (int i = 0; i < 3; i++) begin
      r = 16'($urandom_range(0, 65535));
      vt.push_back(vec_t'{OP_WR,  r,        2'd0, 8'h00});
      vt.push_back(vec_t'{OP_IRQ, 16'h0000, 2'd0, 8'h01});
      vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd2, 8'h01});
      vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd0, r[7:0]});
      vt.push_back(vec_t'{OP_RD,  16'h0000, 2'd1, r[15:8]});
      vt.push_back(vec_t'{OP_IRQ, 16'h0000, 2'd0, 8'h00});
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_main_dout", main_dout, 16'h0000);
    check("rst_sec2", 16'(sec2), 16'd0);
    check("rst_irqn", 16'(mcu_irqn), 16'd1);
    check("rst_status", 16'(mcu_dout), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      case (vt[i].op)
        OP_WR: main_write(vt[i].data);
        OP_RD: begin
          mcu_read(vt[i].addr, rd);
          check($sformatf("mcu_rd[%0d]_a%0d", i, vt[i].addr), 16'(rd), 16'(vt[i].exp));
        end
        default:
          check($sformatf("irqn[%0d]", i), 16'(mcu_irqn), 16'(IRQ_EN ? ~vt[i].exp[0] : 1'b1));
      endcase
    end

    // single reply, then consumed by a 68000 read
    mcu_write(2'd0, 8'hCD);
    mcu_write(2'd1, 8'hAB);
    exp_q.push_back(16'hABCD);
    repeat (14) tick();
    mcu_read(2'd2, rd);
    check("tx_pend_set", 16'(rd), 16'h0002);
    main_rd = 1'b1;
    repeat (2) tick();
    main_rd = 1'b0;
    tick();
    mcu_read(2'd2, rd);
    check("tx_pend_clr", 16'(rd), 16'h0000);
    check("reply_held", main_dout, 16'hABCD);

    // back-to-back commits: queued during PULSE, queue replaced during GAP
    mcu_write(2'd0, 8'h11);
    mcu_write(2'd1, 8'h11);
    exp_q.push_back(16'h1111);
    repeat (2) tick();
    mcu_write(2'd0, 8'h02);
    mcu_write(2'd1, 8'h01);
    exp_q.push_back(16'h0102);
    wait_sec2(1'b0, 20);
    wait_sec2(1'b1, 20);
    mcu_write(2'd0, 8'h22);
    mcu_write(2'd1, 8'h22);
    exp_q.push_back(16'h2222);
    mcu_write(2'd0, 8'h33);
    wait_sec2(1'b0, 20);
    mcu_write(2'd1, 8'h33);
    void'(exp_q.pop_back());
    exp_q.push_back(16'h3333);
    wait_sec2(1'b1, 20);
    wait_sec2(1'b0, 20);
    repeat (4) tick();
    check("queue_final", main_dout, 16'h3333);

    // commit while the 68000 is reading: main_dout frozen until main_rd falls
    main_rd = 1'b1;
    tick();
    mcu_write(2'd0, 8'h66);
    mcu_write(2'd1, 8'h55);
    exp_q.push_back(16'h5566);
    repeat (5) begin
      @(negedge clk);
      check("rd_hold_dout", main_dout, 16'h3333);
      check("rd_hold_sec2", 16'(sec2), 16'd0);
    end
    @(posedge clk);
    #1;
    main_rd = 1'b0;
    wait_sec2(1'b1, 20);
    wait_sec2(1'b0, 20);
    repeat (4) tick();

    // asynchronous reset in the middle of a pulse
    mcu_write(2'd0, 8'h88);
    mcu_write(2'd1, 8'h77);
    exp_q.push_back(16'h7788);
    repeat (3) tick();
    check("mid_pulse_sec2", 16'(sec2), 16'd1);
    rst = 1'b1;
    mcu_addr = 2'd2;
    #1;
    check("arst_sec2", 16'(sec2), 16'd0);
    check("arst_main_dout", main_dout, 16'h0000);
    check("arst_irqn", 16'(mcu_irqn), 16'd1);
    check("arst_status", 16'(mcu_dout), 16'h0000);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    main_write(16'h4321);
    mcu_read(2'd0, rd);
    check("post_rst_lo", 16'(rd), 16'h0021);
    mcu_read(2'd1, rd);
    check("post_rst_hi", 16'(rd), 16'h0043);

    check("pulse_count", 16'(pulses_seen), 16'd6);
    check("replies_left", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
